hud_label_sequencer: RTL and testbench
======================================

# hud_label_sequencer

Sequencer and arbiter that shares one two-glyph player-number bitmap among `NUM_LABELS` on-screen HUD label slots. Each VGA pixel is resolved to at most one slot. The block drives the bitmap's offset, inside-rectangle and glyph-index inputs, and re-tags the bitmap's registered hit with the winning slot's colour. Slot positions are configured through a shadowed valid/ready port and take effect at frame start, so a write never tears a label. The block also blinks the active player's label on a frame counter. It sits between the VGA sync/pixel counter and the object-priority mux.

## Interface
Parameters:
- `NUM_LABELS`, 4: number of label slots; slot id width is `$clog2(NUM_LABELS)`.
- `LABEL_W`, 34: glyph width in pixels.
- `LABEL_H`, 32: glyph height in pixels.
- `BLINK_FRAMES`, 30: frames per blink phase.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: one clock; reset is asynchronous and active-high.
- `pixelX`, in, 11: current pixel column.
- `pixelY`, in, 11: current pixel row.
- `startOfFrame`, in, 1: one-cycle pulse at frame start.
- `cfg_valid`, in, 1: config write request.
- `cfg_ready`, out, 1: config write can be accepted.
- `cfg_sel`, in, 2: target slot.
- `cfg_x`, in, 11: slot top-left column.
- `cfg_y`, in, 11: slot top-left row.
- `cfg_index`, in, 1: glyph index for the slot.
- `cfg_en`, in, 1: slot enable.
- `active_player`, in, 1: glyph index whose labels blink.
- `blink_en`, in, 1: blink enable.
- `bm_offsetX`, out, 11: column offset to the bitmap.
- `bm_offsetY`, out, 11: row offset to the bitmap.
- `bm_inside`, out, 1: inside-rectangle to the bitmap.
- `bm_index`, out, 1: glyph index to the bitmap.
- `bm_hit`, in, 1: bitmap drawing request (1-cycle registered in the bitmap).
- `drawingRequest`, out, 1: this pixel is drawn by a label.
- `RGBout`, out, 8: pixel colour.
- `label_id`, out, 2: slot that produced the pixel.

## Operation
- Slot hit test: pixel is inside slot s when `en[s]`, `pixelX >= x[s]`, `pixelX < x[s]+LABEL_W` and the same holds for Y with `LABEL_H`.
  - Compare in 12 bits so that an `x` near 2047 does not wrap.
  - If the slot's glyph index equals `active_player`, `blink_en`=1 and the blink state is HIDE, the slot is masked and does not hit.
- Arbitration: the lowest-numbered hitting slot wins.
  - The outputs are the winner's offsets (`pixelX-x`, `pixelY-y`, truncated to 11 bits), its index, and `bm_inside`=1.
  - With no winner, `bm_inside`=0 and offsets/index are 0.
- Config: each slot has a live register set and a shadow register set plus a `pending` bit.
  - `cfg_ready` = `!pending[cfg_sel]`.
  - A write on `cfg_valid && cfg_ready` loads the shadow set and sets `pending`.
  - On `startOfFrame`, every pending shadow set copies to live and `pending` clears.
  - A write and `startOfFrame` in the same cycle to the same slot: the write is accepted into the shadow and stays pending until the next frame, not this one.
- Blink FSM: states SHOW and HIDE, plus a frame counter of width `$clog2(BLINK_FRAMES)`.
  - Each `startOfFrame` increments the counter.
  - At `BLINK_FRAMES-1` the counter wraps to 0 and the state toggles.
  - While `blink_en`=0 the state is forced to SHOW and the counter is held at 0.
- Output: `drawingRequest` = registered `bm_hit` AND the delayed slot-valid bit.
  - `RGBout` = `LABEL_COLOR[delayed id]`.
  - When `drawingRequest`=0, `RGBout` is 0 and `label_id` is 0.

## Timing
- Pixel at cycle t drives `bm_*` registered at t+1.
- The bitmap returns `bm_hit` at t+2.
- `drawingRequest`, `RGBout` and `label_id` are registered at t+3, so total latency is 3 cycles.
- The slot id and valid bit travel through a 2-deep delay line aligned with `bm_hit`.
- Live config changes only on the `startOfFrame` edge. A label moved mid-frame appears moved only from the next frame.
- Reset values:
  - All `bm_*` outputs 0; `drawingRequest`, `RGBout`, `label_id` 0.
  - All slots disabled at x=y=0, index 0; `pending` cleared, so `cfg_ready`=1.
  - Blink state SHOW, counter 0; the delay line is cleared.
- Reset asserted mid-frame clears everything immediately. Pending shadow writes are lost.

## Structure
- Package `hud_pkg`:
  - `label_cfg_t` struct {x, y, index, en}.
  - `LABEL_COLOR` palette array, default {8'hFF, 8'hE0, 8'h1C, 8'h03}.
  - `blink_state_t` enum {SHOW, HIDE}.
- Sub-module `hud_label_cfg_bank`: shadow/live registers, pending bits, `cfg_ready`.
- Hit test, arbitration, blink FSM and the delay line stay in the top module.

## Test plan
- Slot0 at (100,50), index 0, enabled; scan pixel (100,50) with `bm_hit`=1 two cycles later -> `bm_offsetX`/`bm_offsetY` = 0/0 at t+1, `drawingRequest`=1 with `RGBout`=8'hFF at t+3.
- Slot0 and slot1 overlap at (200,200); pixel (210,205) -> `label_id`=0, offsets (10,5); pixel (233,231) -> inside; pixel (234,231) -> `bm_inside`=0.
- Write slot2 mid-frame -> no visible change until `startOfFrame`; a second write to slot2 before the frame boundary -> `cfg_ready`=0, held until the frame pulse.
- `blink_en`=1, `active_player`=1, `BLINK_FRAMES`=30 -> index-1 labels hidden for frames 30-59 and visible again at frame 60; index-0 labels are unaffected.
- Slot at x=2040 and pixel 5 -> no hit, checking against wrap. Assert `reset` mid-frame -> all outputs 0 next cycle and `cfg_ready`=1.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared types, palette and span-test helper for the HUD label sequencer.
package hud_pkg;

  localparam int COORD_W = 11;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               index;
    logic               en;
  } label_cfg_t;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_t;

  localparam logic [7:0] LABEL_COLOR [4] = '{8'hFF, 8'hE0, 8'h1C, 8'h03};

  localparam label_cfg_t LABEL_CFG_RESET = '{x: 11'd0, y: 11'd0, index: 1'b0, en: 1'b0};

  // One extra bit keeps origin+len from wrapping near the right/bottom edge.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] origin,
                                   input logic [COORD_W:0]   len);
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    lo = {1'b0, origin};
    hi = lo + len;
    return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

endpackage

// File: rtl/hud_label_cfg_bank.sv
// Shadow/live label configuration with per-slot pending bits; shadows
// are promoted to live only on the frame-start pulse.
module hud_label_cfg_bank
  import hud_pkg::*;
#(
  parameter  int NUM_LABELS = 4,
  localparam int ID_W       = $clog2(NUM_LABELS)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_sof,
  input  logic                              i_cfg_valid,
  output logic                              o_cfg_ready,
  input  logic [ID_W-1:0]                   i_cfg_sel,
  input  logic [COORD_W-1:0]                i_cfg_x,
  input  logic [COORD_W-1:0]                i_cfg_y,
  input  logic                              i_cfg_index,
  input  logic                              i_cfg_en,
  output label_cfg_t [NUM_LABELS-1:0]       o_live
);

  label_cfg_t [NUM_LABELS-1:0] r_live;
  label_cfg_t [NUM_LABELS-1:0] r_shadow;
  logic       [NUM_LABELS-1:0] r_pending;
  logic                        w_accept;
  label_cfg_t                  w_wr_cfg;

  assign o_cfg_ready = !r_pending[i_cfg_sel];
  assign w_accept    = i_cfg_valid && !r_pending[i_cfg_sel];
  assign w_wr_cfg    = '{x: i_cfg_x, y: i_cfg_y, index: i_cfg_index, en: i_cfg_en};
  assign o_live      = r_live;

  // A write landing with the frame pulse stays pending for the following frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_live    <= {NUM_LABELS{LABEL_CFG_RESET}};
      r_shadow  <= {NUM_LABELS{LABEL_CFG_RESET}};
      r_pending <= '0;
    end else begin
      for (int s = 0; s < NUM_LABELS; s++) begin
        if (i_sof && r_pending[s]) begin
          r_live[s]    <= r_shadow[s];
          r_pending[s] <= 1'b0;
        end
        if (w_accept && (i_cfg_sel == ID_W'(s))) begin
          r_shadow[s]  <= w_wr_cfg;
          r_pending[s] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hud_label_sequencer.sv
// Resolves each pixel to at most one HUD label slot, drives the shared glyph
// bitmap and re-colours its registered hit with the winning slot's palette entry.
module hud_label_sequencer
  import hud_pkg::*;
#(
  parameter  int NUM_LABELS   = 4,
  parameter  int LABEL_W      = 34,
  parameter  int LABEL_H      = 32,
  parameter  int BLINK_FRAMES = 30,
  localparam int ID_W         = $clog2(NUM_LABELS),
  localparam int CNT_W        = $clog2(BLINK_FRAMES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COORD_W-1:0]  pixelX,
  input  logic [COORD_W-1:0]  pixelY,
  input  logic                startOfFrame,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ID_W-1:0]     cfg_sel,
  input  logic [COORD_W-1:0]  cfg_x,
  input  logic [COORD_W-1:0]  cfg_y,
  input  logic                cfg_index,
  input  logic                cfg_en,
  input  logic                active_player,
  input  logic                blink_en,
  output logic [COORD_W-1:0]  bm_offsetX,
  output logic [COORD_W-1:0]  bm_offsetY,
  output logic                bm_inside,
  output logic                bm_index,
  input  logic                bm_hit,
  output logic                drawingRequest,
  output logic [7:0]          RGBout,
  output logic [ID_W-1:0]     label_id
);

  label_cfg_t [NUM_LABELS-1:0] w_live;
  logic       [NUM_LABELS-1:0] w_slot_hit;
  logic                        w_win_vld;
  logic       [ID_W-1:0]       w_win_id;
  label_cfg_t                  w_win_cfg;
  logic       [COORD_W-1:0]    w_offx;
  logic       [COORD_W-1:0]    w_offy;
  logic                        w_win_idx;

  blink_state_t                r_blink_state;
  blink_state_t                w_blink_state_nxt;
  logic       [CNT_W-1:0]      r_blink_cnt;
  logic       [CNT_W-1:0]      w_blink_cnt_nxt;
  logic                        w_hide;

  logic       [1:0][ID_W-1:0]  r_id_dly;
  logic       [1:0]            r_vld_dly;
  logic                        w_draw;

  hud_label_cfg_bank #(
    .NUM_LABELS (NUM_LABELS)
  ) u_cfg_bank (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_sof       (startOfFrame),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_x     (cfg_x),
    .i_cfg_y     (cfg_y),
    .i_cfg_index (cfg_index),
    .i_cfg_en    (cfg_en),
    .o_live      (w_live)
  );

  // Blink state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_state <= SHOW;
      r_blink_cnt   <= '0;
    end else begin
      r_blink_state <= w_blink_state_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
    end
  end

  // Blink next state: frame counter wraps and toggles the phase
  always_comb begin
    w_blink_state_nxt = r_blink_state;
    w_blink_cnt_nxt   = r_blink_cnt;
    if (!blink_en) begin
      w_blink_state_nxt = SHOW;
      w_blink_cnt_nxt   = '0;
    end else if (startOfFrame) begin
      if (r_blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        w_blink_cnt_nxt = '0;
        case (r_blink_state)
          SHOW:    w_blink_state_nxt = HIDE;
          HIDE:    w_blink_state_nxt = SHOW;
          default: w_blink_state_nxt = SHOW;
        endcase
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
      end
    end else begin
      w_blink_cnt_nxt = r_blink_cnt;
    end
  end

  // Blink output: mask active-player labels during the hidden phase
  always_comb begin
    w_hide = 1'b0;
    if (blink_en && (r_blink_state == HIDE)) begin
      w_hide = 1'b1;
    end else begin
      w_hide = 1'b0;
    end
  end

  // Per-slot rectangle test with blink masking
  always_comb begin
    w_slot_hit = '0;
    for (int s = 0; s < NUM_LABELS; s++) begin
      w_slot_hit[s] = w_live[s].en
                   && in_span(pixelX, w_live[s].x, 12'(LABEL_W))
                   && in_span(pixelY, w_live[s].y, 12'(LABEL_H))
                   && !(w_hide && (w_live[s].index == active_player));
    end
  end

  // Lowest-numbered hitting slot wins; scanning downward leaves it last
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int s = NUM_LABELS - 1; s >= 0; s--) begin
      if (w_slot_hit[s]) begin
        w_win_vld = 1'b1;
        w_win_id  = ID_W'(s);
      end else begin
        w_win_vld = w_win_vld;
      end
    end
    w_win_cfg = w_live[w_win_id];
    if (w_win_vld) begin
      w_offx    = pixelX - w_win_cfg.x;
      w_offy    = pixelY - w_win_cfg.y;
      w_win_idx = w_win_cfg.index;
    end else begin
      w_offx    = '0;
      w_offy    = '0;
      w_win_idx = 1'b0;
    end
  end

  // Bitmap drive and slot delay line aligned with the bitmap's registered hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bm_offsetX <= '0;
      bm_offsetY <= '0;
      bm_inside  <= 1'b0;
      bm_index   <= 1'b0;
      r_id_dly   <= '0;
      r_vld_dly  <= '0;
    end else begin
      bm_offsetX  <= w_offx;
      bm_offsetY  <= w_offy;
      bm_inside   <= w_win_vld;
      bm_index    <= w_win_idx;
      r_id_dly[0] <= w_win_id;
      r_vld_dly[0] <= w_win_vld;
      r_id_dly[1] <= r_id_dly[0];
      r_vld_dly[1] <= r_vld_dly[0];
    end
  end

  assign w_draw = bm_hit && r_vld_dly[1];

  // Re-tag the bitmap hit with the winning slot's colour
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      label_id       <= '0;
    end else begin
      drawingRequest <= w_draw;
      RGBout         <= w_draw ? LABEL_COLOR[r_id_dly[1]] : 8'h00;
      label_id       <= w_draw ? r_id_dly[1] : '0;
    end
  end

endmodule

// File: tb/tb_hud_label_sequencer.sv
// Scoreboard bench: expectations from a reference model are queued at drive
// time and compared when the DUT pipeline delivers them.
module tb_hud_label_sequencer;

  localparam int NL = 4;
  localparam int LW = 34;
  localparam int LH = 32;
  localparam int BF = 30;
  localparam logic [7:0] PAL [4] = '{8'hFF, 8'hE0, 8'h1C, 8'h03};

  logic        clk;
  logic        reset;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, cfg_valid, cfg_ready;
  logic [1:0]  cfg_sel;
  logic [10:0] cfg_x, cfg_y;
  logic        cfg_index, cfg_en, active_player, blink_en;
  logic [10:0] bm_offsetX, bm_offsetY;
  logic        bm_inside, bm_index, bm_hit, drawingRequest;
  logic [7:0]  RGBout;
  logic [1:0]  label_id;

  hud_label_sequencer dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_index(cfg_index),
    .cfg_en(cfg_en), .active_player(active_player), .blink_en(blink_en),
    .bm_offsetX(bm_offsetX), .bm_offsetY(bm_offsetY), .bm_inside(bm_inside),
    .bm_index(bm_index), .bm_hit(bm_hit), .drawingRequest(drawingRequest),
    .RGBout(RGBout), .label_id(label_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [23:0] v; } exp_t;
  typedef struct { int due; logic g; } hit_t;

  exp_t q_bm[$];
  exp_t q_out[$];
  hit_t q_hit[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [10:0]   m_x [NL];
  logic [10:0]   m_y [NL];
  logic [10:0]   s_x [NL];
  logic [10:0]   s_y [NL];
  logic [NL-1:0] m_idx, m_en, s_idx, s_en, m_pend;
  logic          m_blink, m_ap;
  int            m_frames;

  exp_t        mon_e;
  logic [23:0] mon_act;

  // Scoreboard: compare whatever the pipeline owes at this edge
  always @(posedge clk) begin
    cyc++;
    #1;
    if (q_bm.size() > 0 && q_bm[0].due == cyc) begin
      mon_e   = q_bm.pop_front();
      mon_act = {bm_inside, bm_offsetX, bm_offsetY, bm_index};
      checks++;
      if (mon_act !== mon_e.v) begin
        errors++;
        $display("FAIL bm_stage cyc %0d: got %h expected %h", cyc, mon_act, mon_e.v);
      end
    end
    if (q_out.size() > 0 && q_out[0].due == cyc) begin
      mon_e   = q_out.pop_front();
      mon_act = {13'd0, drawingRequest, RGBout, label_id};
      checks++;
      if (mon_act !== mon_e.v) begin
        errors++;
        $display("FAIL pixel_out cyc %0d: got %h expected %h", cyc, mon_act, mon_e.v);
      end
    end
  end

  function automatic void model(input int px, input int py,
                                output logic [23:0] bmv, output logic ins,
                                output logic [1:0] wid);
    logic hide;
    hide = m_blink && (((m_frames / BF) % 2) == 1);
    ins  = 1'b0;
    wid  = 2'd0;
    bmv  = 24'd0;
    for (int s = 0; s < NL; s++) begin
      if (!ins && m_en[s]
          && px >= int'(m_x[s]) && px < int'(m_x[s]) + LW
          && py >= int'(m_y[s]) && py < int'(m_y[s]) + LH
          && !(hide && (m_idx[s] == m_ap))) begin
        ins = 1'b1;
        wid = 2'(s);
        bmv = {1'b1, 11'(px - int'(m_x[s])), 11'(py - int'(m_y[s])), m_idx[s]};
      end
    end
  endfunction

  function automatic void model_sof();
    for (int s = 0; s < NL; s++) begin
      if (m_pend[s]) begin
        m_x[s] = s_x[s]; m_y[s] = s_y[s]; m_idx[s] = s_idx[s]; m_en[s] = s_en[s];
        m_pend[s] = 1'b0;
      end
    end
    if (m_blink) m_frames++;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NL; s++) begin
      m_x[s] = 11'd0; m_y[s] = 11'd0; s_x[s] = 11'd0; s_y[s] = 11'd0;
    end
    m_idx = '0; m_en = '0; s_idx = '0; s_en = '0; m_pend = '0;
    m_frames = 0;
  endfunction

  // One cycle: the bench plays the bitmap, returning its hit two cycles on
  task automatic tick();
    hit_t h;
    @(negedge clk);
    bm_hit = 1'b0;
    if (q_hit.size() > 0 && q_hit[0].due == cyc) begin
      h = q_hit.pop_front();
      bm_hit = h.g;
    end
  endtask

  task automatic pix(input int px, input int py, input logic g);
    logic [23:0] bmv;
    logic        ins, d;
    logic [1:0]  wid;
    tick();
    pixelX = 11'(px);
    pixelY = 11'(py);
    model(px, py, bmv, ins, wid);
    d = g & ins;
    q_bm.push_back('{due: cyc + 1, v: bmv});
    q_hit.push_back('{due: cyc + 2, g: g});
    q_out.push_back('{due: cyc + 3, v: {13'd0, d, (d ? PAL[wid] : 8'h00), (d ? wid : 2'd0)}});
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic frame();
    tick();
    startOfFrame = 1'b1;
    model_sof();
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic cfg_write(input int sel, input int x, input int y,
                           input logic idx, input logic en, input logic with_sof);
    logic rdy;
    tick();
    cfg_valid = 1'b1; cfg_sel = 2'(sel); cfg_x = 11'(x); cfg_y = 11'(y);
    cfg_index = idx; cfg_en = en; startOfFrame = with_sof;
    rdy = !m_pend[sel];
    #1;
    checks++;
    if (cfg_ready !== rdy) begin
      errors++;
      $display("FAIL cfg_ready_on_write slot %0d: got %b expected %b", sel, cfg_ready, rdy);
    end
    if (with_sof) model_sof();
    if (rdy) begin
      s_x[sel] = 11'(x); s_y[sel] = 11'(y); s_idx[sel] = idx; s_en[sel] = en;
      m_pend[sel] = 1'b1;
    end
    tick();
    cfg_valid = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    reset = 1'b1;
    tick();
    tick();
    outs = {bm_inside, bm_offsetX, bm_offsetY, bm_index, drawingRequest, RGBout, label_id};
    checks++;
    if (outs !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    cfg_write(0, 100, 50, 1'b0, 1'b1, 1'b0);
    frame();
    pix(100, 50, 1'b1);
    pix(99, 50, 1'b1);
    pix(133, 81, 1'b1);
    pix(134, 81, 1'b1);
    pix(100, 82, 1'b1);
    pix(120, 60, 1'b0);
    drain();
  endtask

  task automatic test_overlap();
    cfg_write(0, 200, 200, 1'b0, 1'b1, 1'b0);
    cfg_write(1, 200, 200, 1'b1, 1'b1, 1'b0);
    frame();
    pix(210, 205, 1'b1);
    pix(233, 231, 1'b1);
    pix(234, 231, 1'b1);
    pix(200, 232, 1'b1);
    cfg_write(0, 200, 200, 1'b0, 1'b0, 1'b0);
    frame();
    pix(210, 205, 1'b1);
    drain();
  endtask

  task automatic test_shadow();
    cfg_write(2, 400, 300, 1'b0, 1'b1, 1'b0);
    pix(410, 310, 1'b1);
    cfg_sel = 2'd2;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_blocks_ready: got %b expected 0", cfg_ready);
    end
    cfg_write(2, 500, 300, 1'b0, 1'b1, 1'b0);
    tick();
    cfg_sel = 2'd3;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL other_slot_ready: got %b expected 1", cfg_ready);
    end
    pix(410, 310, 1'b1);
    frame();
    cfg_sel = 2'd2;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_frame: got %b expected 1", cfg_ready);
    end
    pix(410, 310, 1'b1);
    pix(510, 310, 1'b1);
    // write coinciding with the frame pulse waits one more frame
    cfg_write(3, 600, 100, 1'b0, 1'b1, 1'b1);
    cfg_sel = 2'd3;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL sof_write_pending: got %b expected 0", cfg_ready);
    end
    pix(605, 105, 1'b1);
    frame();
    pix(605, 105, 1'b1);
    drain();
  endtask

  task automatic test_blink();
    tick();
    active_player = 1'b1; m_ap = 1'b1;
    blink_en = 1'b1; m_blink = 1'b1; m_frames = 0;
    for (int f = 1; f <= 61; f++) begin
      frame();
      pix(210, 205, 1'b1);
      pix(410, 310, 1'b1);
    end
    drain();
    blink_en = 1'b0; m_blink = 1'b0; m_frames = 0;
    pix(210, 205, 1'b1);
    drain();
  endtask

  task automatic test_wrap();
    cfg_write(3, 2040, 0, 1'b0, 1'b1, 1'b0);
    frame();
    pix(2045, 5, 1'b1);
    pix(5, 5, 1'b1);
    pix(2047, 31, 1'b1);
    pix(2047, 32, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      pix(int'($urandom_range(190, 250)), int'($urandom_range(190, 240)),
          1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    logic [33:0] outs;
    cfg_write(0, 100, 50, 1'b0, 1'b1, 1'b0);
    pix(210, 205, 1'b1);
    pix(210, 205, 1'b1);
    tick();
    reset = 1'b1;
    q_bm.delete();
    q_out.delete();
    q_hit.delete();
    bm_hit = 1'b0;
    cfg_sel = 2'd0;
    @(posedge clk);
    #1;
    outs = {bm_inside, bm_offsetX, bm_offsetY, bm_index, drawingRequest, RGBout, label_id};
    checks++;
    if (outs !== 34'd0) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset_ready: got %b expected 1", cfg_ready);
    end
    tick();
    reset = 1'b0;
    model_clear();
    frame();
    pix(100, 50, 1'b1);
    pix(210, 205, 1'b1);
    drain();
    checks++;
    if (q_out.size() != 0 || q_bm.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d/%0d pending expected 0/0",
               q_bm.size(), q_out.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    pixelX = 11'd0; pixelY = 11'd0; startOfFrame = 1'b0;
    cfg_valid = 1'b0; cfg_sel = 2'd0; cfg_x = 11'd0; cfg_y = 11'd0;
    cfg_index = 1'b0; cfg_en = 1'b0; active_player = 1'b0; blink_en = 1'b0;
    bm_hit = 1'b0;
    m_blink = 1'b0; m_ap = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_overlap();
    test_shadow();
    test_blink();
    test_wrap();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
